spi_reg_bridge: RTL and testbench

//  SPI slave (mode 0) that is the initiator of the peripheral register bus.

---
 rtl/spi_reg_bridge.sv | 187 ++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns one cs_n frame into a single register-bus access.
// Frame layout: command byte (bit7 = write, bit6 ignored, bits5:0 = address)
// followed by DATA_W data bits, MSB first. Everything runs in the clk domain.
module spi_reg_bridge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read
);

  localparam int unsigned CNT_MAX = (DATA_W > 8) ? DATA_W : 8;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    CMD,
    DECODE,
    DATA_WR,
    DATA_RD,
    DONE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   sclk_d;
  logic                   cs_d;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  logic [CNT_W-1:0]  bit_cnt;
  logic [6:0]        cmd_sr;
  logic              cmd_wr;
  logic [DATA_W-2:0] data_sr;
  logic [DATA_W-1:0] tx_sr;
  logic [7:0]        cmd_next;
  logic [DATA_W-1:0] data_next;

  // Synchronise the SPI pins and keep the previous synced value for edge detection.
  // cs_n resets low so a frame already in progress at reset release is not seen as a new cs_fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sr <= '0;
      cs_sr   <= '0;
      mosi_sr <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sclk_d  <= sclk_sr[SYNC_STAGES-1];
      cs_d    <= cs_sr[SYNC_STAGES-1];
    end
  end

  // Edge pulses and the shift-register next values.
  always_comb begin
    sclk_s    = sclk_sr[SYNC_STAGES-1];
    cs_s      = cs_sr[SYNC_STAGES-1];
    mosi_s    = mosi_sr[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_d;
    sclk_fall = ~sclk_s & sclk_d;
    cs_rise   = cs_s & ~cs_d;
    cs_fall   = ~cs_s & cs_d;
    cmd_next  = {cmd_sr, mosi_s};
    data_next = {data_sr, mosi_s};
  end

  // miso is the MSB of the transmit register, which is held at zero outside a read data phase.
  assign miso = tx_sr[DATA_W-1];

  // Frame sequencer: command decode, data shift, single bus strobe per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_IDLE;
      bit_cnt    <= '0;
      cmd_sr     <= '0;
      cmd_wr     <= 1'b0;
      data_sr    <= '0;
      tx_sr      <= '0;
      addr       <= '0;
      data_write <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
    end else begin
      read  <= 1'b0;
      write <= 1'b0;
      if (cs_rise) begin
        state <= IDLE;
        tx_sr <= '0;
      end else begin
        case (state)
          WAIT_IDLE: begin
            tx_sr <= '0;
            if (cs_s) state <= IDLE;
          end
          IDLE: begin
            tx_sr <= '0;
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
              cmd_sr  <= '0;
              data_sr <= '0;
            end
          end
          CMD: begin
            tx_sr <= '0;
            if (sclk_rise) begin
              cmd_sr  <= cmd_next[6:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(7)) begin
                addr   <= ADDR_W'(cmd_next[5:0]);
                cmd_wr <= cmd_next[7];
                state  <= DECODE;
              end
            end
          end
          DECODE: begin
            bit_cnt <= '0;
            if (cmd_wr) begin
              state <= DATA_WR;
            end else begin
              read  <= 1'b1;
              state <= DATA_RD;
            end
          end
          DATA_WR: begin
            if (sclk_rise) begin
              data_sr <= data_next[DATA_W-2:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                data_write <= data_next;
                write      <= 1'b1;
                state      <= DONE;
              end
            end
          end
          DATA_RD: begin
            // The load happens at the end of the read cycle so data_read is sampled against the
            // new address. The first fall seen here is the command's 8th fall and only advances
            // the count; each later fall exposes the next bit.
            if (read) begin
              tx_sr <= data_read;
            end else if (sclk_fall) begin
              if (bit_cnt == CNT_W'(DATA_W)) begin
                tx_sr <= '0;
                state <= DONE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt != '0) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
              end
            end
          end
          DONE: begin
            tx_sr <= '0;
          end
          default: begin
            state <= WAIT_IDLE;
            tx_sr <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: a mode-0 SPI master task drives frames and a
// small register-file model answers reads; each scenario task checks its own results.
module tb_spi_reg_bridge;

  localparam int unsigned HALF = 80;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk  = 1'b0;
  logic       cs_n  = 1'b1;
  logic       mosi  = 1'b0;
  logic       miso;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;

  int unsigned wr_total   = 0;
  int unsigned rd_total   = 0;
  int unsigned both_total = 0;
  logic [5:0]  wr_addr    = '0;
  logic [7:0]  wr_data    = '0;
  logic [5:0]  rd_addr    = '0;

  logic [7:0] regs [64];

  always #5 clk = ~clk;

  spi_reg_bridge #(
    .SYNC_STAGES(2),
    .ADDR_W(6),
    .DATA_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk(sclk),
    .cs_n(cs_n),
    .mosi(mosi),
    .miso(miso),
    .read(read),
    .write(write),
    .addr(addr),
    .data_write(data_write),
    .data_read(data_read)
  );

  // Register file model: 0x0D is a fixed 0xA5 location, everything else is RAM.
  always @(posedge clk) if (write) regs[addr] <= data_write;
  assign data_read = (addr == 6'h0D) ? 8'hA5 : regs[addr];

  // Strobe monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (write) begin
      wr_total = wr_total + 1;
      wr_addr  = addr;
      wr_data  = data_write;
    end
    if (read) begin
      rd_total = rd_total + 1;
      rd_addr  = addr;
    end
    if (read && write) both_total = both_total + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic spi_start();
    cs_n = 1'b0;
  endtask

  task automatic spi_bits(input logic [23:0] bits, input int unsigned n, output logic [23:0] rx);
    rx = '0;
    for (int unsigned i = 0; i < n; i++) begin
      mosi = bits[n-1-i];
      #HALF;
      sclk = 1'b1;
      rx   = {rx[22:0], miso};
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic spi_stop();
    #HALF;
    cs_n = 1'b1;
    mosi = 1'b0;
    #HALF;
  endtask

  task automatic spi_frame(input logic [23:0] bits, input int unsigned n, output logic [23:0] rx);
    spi_start();
    spi_bits(bits, n, rx);
    spi_stop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_cnt++; if (read !== 1'b0) $display("FAIL reset_read: got %b expected 0", read); else pass_cnt++;
    chk_cnt++; if (write !== 1'b0) $display("FAIL reset_write: got %b expected 0", write); else pass_cnt++;
    chk_cnt++; if (addr !== 6'h00) $display("FAIL reset_addr: got %h expected 00", addr); else pass_cnt++;
    chk_cnt++; if (data_write !== 8'h00) $display("FAIL reset_data_write: got %h expected 00", data_write); else pass_cnt++;
    chk_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso: got %b expected 0", miso); else pass_cnt++;
  endtask

  task automatic test_write();
    logic [23:0] rx;
    int unsigned w0, r0;
    w0 = wr_total; r0 = rd_total;
    spi_frame(24'h008034, 16, rx);
    repeat (10) @(negedge clk);
    chk_cnt++; if (wr_total - w0 != 1) $display("FAIL write_count: got %0d expected 1", wr_total - w0); else pass_cnt++;
    chk_cnt++; if (rd_total - r0 != 0) $display("FAIL write_no_read: got %0d expected 0", rd_total - r0); else pass_cnt++;
    chk_cnt++; if (wr_addr !== 6'h00) $display("FAIL write_addr: got %h expected 00", wr_addr); else pass_cnt++;
    chk_cnt++; if (wr_data !== 8'h34) $display("FAIL write_data: got %h expected 34", wr_data); else pass_cnt++;
  endtask

  task automatic test_read();
    logic [23:0] rx;
    int unsigned w0, r0;
    w0 = wr_total; r0 = rd_total;
    spi_frame(24'h000D00, 16, rx);
    repeat (10) @(negedge clk);
    chk_cnt++; if (rd_total - r0 != 1) $display("FAIL read_count: got %0d expected 1", rd_total - r0); else pass_cnt++;
    chk_cnt++; if (wr_total - w0 != 0) $display("FAIL read_no_write: got %0d expected 0", wr_total - w0); else pass_cnt++;
    chk_cnt++; if (rd_addr !== 6'h0D) $display("FAIL read_addr: got %h expected 0d", rd_addr); else pass_cnt++;
    chk_cnt++; if (rx[15:8] !== 8'h00) $display("FAIL read_miso_cmd_phase: got %h expected 00", rx[15:8]); else pass_cnt++;
    chk_cnt++; if (rx[7:0] !== 8'hA5) $display("FAIL read_miso_data: got %h expected a5", rx[7:0]); else pass_cnt++;
    chk_cnt++; if (miso !== 1'b0) $display("FAIL read_miso_idle: got %b expected 0", miso); else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [23:0] rx;
    int unsigned w0, r0;
    w0 = wr_total; r0 = rd_total;
    spi_frame(24'h00082F, 12, rx);
    repeat (20) @(negedge clk);
    chk_cnt++; if (wr_total - w0 != 0) $display("FAIL abort_no_write: got %0d expected 0", wr_total - w0); else pass_cnt++;
    chk_cnt++; if (rd_total - r0 != 0) $display("FAIL abort_no_read: got %0d expected 0", rd_total - r0); else pass_cnt++;
  endtask

  task automatic test_long_frame();
    logic [23:0] rx;
    int unsigned w0, r0;
    w0 = wr_total; r0 = rd_total;
    spi_frame(24'hC17E55, 24, rx);
    repeat (10) @(negedge clk);
    chk_cnt++; if (wr_total - w0 != 1) $display("FAIL long_write_count: got %0d expected 1", wr_total - w0); else pass_cnt++;
    chk_cnt++; if (rd_total - r0 != 0) $display("FAIL long_no_read: got %0d expected 0", rd_total - r0); else pass_cnt++;
    chk_cnt++; if (wr_addr !== 6'h01) $display("FAIL long_addr: got %h expected 01", wr_addr); else pass_cnt++;
    chk_cnt++; if (wr_data !== 8'h7E) $display("FAIL long_data: got %h expected 7e", wr_data); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    logic [23:0] rx;
    int unsigned w0, r0;
    w0 = wr_total; r0 = rd_total;
    spi_start();
    spi_bits(24'h00021C, 10, rx);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++; if (addr !== 6'h00) $display("FAIL midreset_addr: got %h expected 00", addr); else pass_cnt++;
    chk_cnt++; if (data_write !== 8'h00) $display("FAIL midreset_data_write: got %h expected 00", data_write); else pass_cnt++;
    spi_bits(24'h000001, 6, rx);
    spi_stop();
    repeat (10) @(negedge clk);
    chk_cnt++; if (wr_total - w0 != 0) $display("FAIL midreset_no_write: got %0d expected 0", wr_total - w0); else pass_cnt++;
    chk_cnt++; if (rd_total - r0 != 0) $display("FAIL midreset_no_read: got %0d expected 0", rd_total - r0); else pass_cnt++;
    spi_frame(24'h008701, 16, rx);
    repeat (10) @(negedge clk);
    chk_cnt++; if (wr_total - w0 != 1) $display("FAIL postreset_write_count: got %0d expected 1", wr_total - w0); else pass_cnt++;
    chk_cnt++; if (wr_addr !== 6'h07) $display("FAIL postreset_addr: got %h expected 07", wr_addr); else pass_cnt++;
    chk_cnt++; if (wr_data !== 8'h01) $display("FAIL postreset_data: got %h expected 01", wr_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] rx;
    int unsigned w0, r0;
    w0 = wr_total; r0 = rd_total;
    spi_frame(24'h008A10, 16, rx);
    #HALF;
    spi_frame(24'h000A00, 16, rx);
    repeat (10) @(negedge clk);
    chk_cnt++; if (wr_total - w0 != 1) $display("FAIL b2b_write_count: got %0d expected 1", wr_total - w0); else pass_cnt++;
    chk_cnt++; if (rd_total - r0 != 1) $display("FAIL b2b_read_count: got %0d expected 1", rd_total - r0); else pass_cnt++;
    chk_cnt++; if (rd_addr !== 6'h0A) $display("FAIL b2b_read_addr: got %h expected 0a", rd_addr); else pass_cnt++;
    chk_cnt++; if (rx[7:0] !== 8'h10) $display("FAIL b2b_miso_data: got %h expected 10", rx[7:0]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    repeat (20) @(negedge clk);
    test_read();
    repeat (20) @(negedge clk);
    test_abort();
    test_long_frame();
    repeat (20) @(negedge clk);
    test_reset_midframe();
    repeat (20) @(negedge clk);
    test_back_to_back();
    chk_cnt++; if (both_total != 0) $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", both_total); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
